console_bridge: RTL

- Parametrised next-generation console bridge between the PS-side AXI GPIO word pair and the soft CPU console put/get method interfaces.
- Two independent FIFOs:
  - RX: GPIO -> CPU `put`.
  - TX: CPU `get` -> GPIO.
- Generalised in data width and depth.
- Adds a loss-free put holding register, first-word-fall-through TX readout, overflow detection with sticky flags, and per-direction flush.

---
 rtl/console_pkg.sv | 29 ++
 rtl/console_fifo.sv | 62 ++++++
 rtl/console_bridge.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/console_pkg.sv
// Shared constants and types for the console bridge: GPIO bit map and strobe bundle.
package console_pkg;

  // gpio_in control strobes
  localparam int RX_WR_BIT    = 16;
  localparam int TX_RD_BIT    = 17;
  localparam int CLR_BIT      = 18;
  localparam int FLUSH_RX_BIT = 19;
  localparam int FLUSH_TX_BIT = 20;

  // gpio_out status bits
  localparam int TX_EMPTY_BIT = 16;
  localparam int RX_FULL_BIT  = 17;
  localparam int RX_OVF_BIT   = 18;
  localparam int TX_OVF_BIT   = 19;

  // Widest character the 16-bit data field of the GPIO words can carry
  localparam int MAX_DATA_WIDTH = 16;

  // gpio_in[20:16] viewed as a bundle; first field is the MSB (bit 20)
  typedef struct packed {
    logic flush_tx;
    logic flush_rx;
    logic clr;
    logic tx_rd;
    logic rx_wr;
  } strobe_t;

endpackage

// File: rtl/console_fifo.sv
// Synchronous first-word-fall-through FIFO; any DEPTH >= 2, flush clears in one cycle.
module console_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_do_pop;
  logic                  w_do_push;

  // Pointers wrap explicitly so DEPTH need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a push on full is legal alongside it
  assign w_do_push = push & (~full | w_do_pop);

  // Pointer and occupancy update; flush discards everything including a same-cycle push
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since the count gates every read
  always_ff @(posedge clk) begin
    if (w_do_push && !flush && !rst) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/console_bridge.sv
// Console bridge: GPIO word pair <-> soft CPU put/get, with RX/TX FIFOs and sticky overflow flags.
module console_bridge
  import console_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,     // 1..MAX_DATA_WIDTH
  parameter  int DEPTH      = 1024,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           gpio_in,
  output logic [31:0]           gpio_out,
  input  logic                  cpu_reset_completed,
  input  logic                  put_rdy,
  output logic                  put_en,
  output logic [DATA_WIDTH-1:0] put_data,
  input  logic                  get_rdy,
  input  logic [DATA_WIDTH-1:0] get_data,
  output logic [CNT_W-1:0]      rx_count,
  output logic [CNT_W-1:0]      tx_count
);

  strobe_t               r_stb_prev;
  logic                  r_armed;
  strobe_t               w_stb_lvl;
  strobe_t               w_rise;

  logic                  r_hold_valid;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_rx_ovf;
  logic                  r_tx_ovf;
  logic [31:0]           r_gpio_out;
  logic [31:0]           w_gpio_nxt;

  logic                  w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_ovf_evt;
  logic [DATA_WIDTH-1:0] w_rx_dout;
  logic                  w_tx_pop, w_tx_full, w_tx_empty, w_tx_ovf_evt;
  logic [DATA_WIDTH-1:0] w_tx_dout;
  logic                  w_put_en;
  logic                  w_unused_gpio;

  assign w_stb_lvl     = strobe_t'(gpio_in[FLUSH_TX_BIT:RX_WR_BIT]);
  // r_armed stays low for the first cycle after reset, so a strobe held high
  // through reset is absorbed into the history instead of firing on release
  assign w_rise        = strobe_t'(w_stb_lvl & ~r_stb_prev & {$bits(strobe_t){r_armed}});
  assign w_unused_gpio = ^gpio_in;

  // Strobe history for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stb_prev <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_stb_prev <= w_stb_lvl;
      r_armed    <= 1'b1;
    end
  end

  // ---------------- RX: GPIO -> FIFO -> holding register -> put ----------------
  // Full is judged before any same-cycle pop: a pop never makes room for this push
  assign w_rx_push    = w_rise.rx_wr & ~w_rx_full;
  assign w_rx_ovf_evt = w_rise.rx_wr &  w_rx_full;
  assign w_put_en     = r_hold_valid & put_rdy & cpu_reset_completed;
  // Refill whenever the holder is free or being emptied this cycle: 1 char/cycle
  assign w_rx_pop     = ~w_rx_empty & (~r_hold_valid | w_put_en) & ~w_rise.flush_rx;

  console_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .flush (w_rise.flush_rx),
    .din   (gpio_in[DATA_WIDTH-1:0]),
    .dout  (w_rx_dout),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (rx_count)
  );

  // Holding register: a char only leaves on put_en, so put_rdy drops lose nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_rise.flush_rx) begin
      r_hold_valid <= 1'b0;
    end else if (w_rx_pop) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= w_rx_dout;
    end else if (w_put_en) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign put_en   = w_put_en;
  assign put_data = r_hold_data;

  // ---------------- TX: get -> FIFO -> GPIO ----------------
  assign w_tx_pop     = w_rise.tx_rd & ~w_tx_empty;
  // A pop in the same cycle frees a slot, so only a push without one overflows
  assign w_tx_ovf_evt = get_rdy & w_tx_full & ~w_tx_pop;

  console_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (get_rdy),
    .pop   (w_tx_pop),
    .flush (w_rise.flush_tx),
    .din   (get_data),
    .dout  (w_tx_dout),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (tx_count)
  );

  // Sticky overflow flags; a new overflow beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
    end else begin
      r_rx_ovf <= w_rx_ovf_evt | (r_rx_ovf & ~w_rise.clr);
      r_tx_ovf <= w_tx_ovf_evt | (r_tx_ovf & ~w_rise.clr);
    end
  end

  // Status word assembled from current state, unused bits zero
  always_comb begin
    w_gpio_nxt                   = '0;
    w_gpio_nxt[DATA_WIDTH-1:0]   = w_tx_dout;
    w_gpio_nxt[TX_EMPTY_BIT]     = w_tx_empty;
    w_gpio_nxt[RX_FULL_BIT]      = w_rx_full;
    w_gpio_nxt[RX_OVF_BIT]       = r_rx_ovf;
    w_gpio_nxt[TX_OVF_BIT]       = r_tx_ovf;
  end

  // Registered status output, trails state by one cycle
  always_ff @(posedge clk) begin
    if (rst) r_gpio_out <= 32'h0001_0000;
    else     r_gpio_out <= w_gpio_nxt;
  end

  assign gpio_out = r_gpio_out;

endmodule
